// File: rtl/motor_soft_start_pwm.sv
// Soft-start motor drive: ramps the applied duty toward a commanded target one step per
// divided-clock tick, forces a ramp to zero before reversing, and emits a registered PWM.
module motor_soft_start_pwm #(
  parameter int RAMP_STEP = 4,
  parameter int PWM_TOP   = 254
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic [7:0] target_duty,
  input  logic       dir_cmd,
  output logic       pwm_out,
  output logic       dir_out,
  output logic [7:0] duty_now,
  output logic       at_target
);

  typedef enum logic [2:0] {IDLE, UP, DOWN, HOLD, REVERSE} state_t;

  localparam int CW = ($clog2(PWM_TOP + 1) > 8) ? $clog2(PWM_TOP + 1) : 8;
  localparam logic [8:0] STEP9 = 9'(RAMP_STEP);

  logic          sync1_reg, sync2_reg, prev_reg;
  logic          tick_pulse;
  logic [7:0]    duty_reg, duty_next, duty_act_reg;
  logic          dir_reg, dir_next;
  logic [CW-1:0] cnt_reg;
  logic          pwm_reg;
  state_t        state_reg, state_next;
  logic [7:0]    eff;
  logic [8:0]    sum9, diff9;

  assign tick_pulse = sync2_reg & ~prev_reg;
  assign eff        = (dir_cmd != dir_reg) ? 8'd0 : target_duty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
      duty_reg  <= 8'd0;
      dir_reg   <= 1'b0;
      state_reg <= IDLE;
    end else begin
      sync1_reg <= tick_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      duty_reg  <= duty_next;
      dir_reg   <= dir_next;
      state_reg <= state_next;
    end
  end

  // The step decision uses the live classification so a target or direction change in the
  // same cycle as a tick can never cause a jump; the registered state gates the reversal.
  always_comb begin
    state_next = IDLE;
    duty_next  = duty_reg;
    dir_next   = dir_reg;
    sum9       = {1'b0, duty_reg} + STEP9;
    diff9      = {1'b0, duty_reg} - STEP9;

    if (dir_cmd != dir_reg)                  state_next = REVERSE;
    else if (duty_reg == 8'd0 && eff == 8'd0) state_next = IDLE;
    else if (duty_reg < eff)                  state_next = UP;
    else if (duty_reg > eff)                  state_next = DOWN;
    else                                      state_next = HOLD;

    if (tick_pulse) begin
      case (state_next)
        UP:            duty_next = (sum9 > {1'b0, eff}) ? eff : sum9[7:0];
        DOWN, REVERSE: duty_next = (diff9[8] || diff9[7:0] < eff) ? eff : diff9[7:0];
        default:       duty_next = duty_reg;
      endcase
    end

    if (state_reg == REVERSE && state_next == REVERSE && duty_reg == 8'd0)
      dir_next = ~dir_reg;
  end

  // New duty is latched only at the period boundary so every PWM period is whole.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      duty_act_reg <= 8'd0;
      pwm_reg      <= 1'b0;
    end else begin
      if (cnt_reg == CW'(PWM_TOP)) begin
        cnt_reg      <= '0;
        duty_act_reg <= duty_reg;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      pwm_reg <= (cnt_reg < CW'(duty_act_reg));
    end
  end

  assign pwm_out   = pwm_reg;
  assign dir_out   = dir_reg;
  assign duty_now  = duty_reg;
  assign at_target = (duty_reg == target_duty) && (dir_reg == dir_cmd);

endmodule

// File: tb/tb_motor_soft_start_pwm.sv
// Directed bench for motor_soft_start_pwm: vector table for ramp/reversal steps plus
// hand sequences for tick latency, clamping, PWM high-time, async reset and a long tick.
module tb_motor_soft_start_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_in = 1'b0;
  logic [7:0] target_duty = 8'd0;
  logic       dir_cmd = 1'b0;
  logic       pwm_out, dir_out, at_target;
  logic [7:0] duty_now;

  int n_vec = 0;
  int n_bad = 0;

  motor_soft_start_pwm #(.RAMP_STEP(4), .PWM_TOP(254)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .target_duty(target_duty),
    .dir_cmd(dir_cmd), .pwm_out(pwm_out), .dir_out(dir_out),
    .duty_now(duty_now), .at_target(at_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tgt;
    logic       dir;
    int         ticks;
    logic [7:0] exp_duty;
    logic       exp_dir;
    logic       exp_at;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int hold);
    @(negedge clk) tick_in = 1'b1;
    repeat (hold) @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ramp_to(input logic [7:0] val, input int max_ticks);
    int n = 0;
    while (duty_now != val && n < max_ticks) begin
      tick(2);
      n++;
    end
    chk($sformatf("ramp_to_%0d", val), int'(duty_now), int'(val));
  endtask

  task automatic pwm_count(input string name, input int exp);
    int hi = 0;
    repeat (2 * 255) @(negedge clk);
    repeat (255) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
    chk(name, hi, exp);
  endtask

  initial begin
    // tgt, dir, ticks, duty, dir_out, at_target
    vecs[0]  = '{8'd10,  1'b0, 1, 8'd8,  1'b0, 1'b0};
    vecs[1]  = '{8'd10,  1'b0, 1, 8'd10, 1'b0, 1'b1};
    vecs[2]  = '{8'd10,  1'b0, 1, 8'd10, 1'b0, 1'b1};
    vecs[3]  = '{8'd200, 1'b0, 0, 8'd10, 1'b0, 1'b0};
    vecs[4]  = '{8'd10,  1'b0, 0, 8'd10, 1'b0, 1'b1};
    vecs[5]  = '{8'd12,  1'b0, 1, 8'd12, 1'b0, 1'b1};
    vecs[6]  = '{8'd12,  1'b1, 1, 8'd8,  1'b0, 1'b0};
    vecs[7]  = '{8'd12,  1'b0, 1, 8'd12, 1'b0, 1'b1};
    vecs[8]  = '{8'd12,  1'b1, 1, 8'd8,  1'b0, 1'b0};
    vecs[9]  = '{8'd12,  1'b1, 1, 8'd4,  1'b0, 1'b0};
    vecs[10] = '{8'd12,  1'b1, 1, 8'd0,  1'b1, 1'b0};
    vecs[11] = '{8'd12,  1'b1, 1, 8'd4,  1'b1, 1'b0};
    vecs[12] = '{8'd12,  1'b1, 1, 8'd8,  1'b1, 1'b0};
    vecs[13] = '{8'd12,  1'b1, 1, 8'd12, 1'b1, 1'b1};
    vecs[14] = '{8'd12,  1'b1, 1, 8'd12, 1'b1, 1'b1};
    vecs[15] = '{8'd16,  1'b1, 0, 8'd12, 1'b1, 1'b0};
    vecs[16] = '{8'd16,  1'b1, 1, 8'd16, 1'b1, 1'b1};

    // Reset state, observed while reset is asserted
    #2 rst = 1'b1;
    #1;
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_duty", int'(duty_now), 0);
    chk("rst_dir", int'(dir_out), 0);
    chk("rst_at_target", int'(at_target), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // First step and its latency: tick sampled at edge 1, duty moves at edge 3
    target_duty = 8'd10;
    @(negedge clk) tick_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("latency_edge2", int'(duty_now), 0);
    @(posedge clk);
    #1 chk("latency_edge3", int'(duty_now), 4);
    @(negedge clk) tick_in = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      target_duty = vecs[i].tgt;
      dir_cmd     = vecs[i].dir;
      if (vecs[i].ticks == 0) repeat (6) @(negedge clk);
      else tick((i % 2 == 0) ? 1 : 2);
      $display("vec %0d: tgt=%0d dir=%0d duty=%0d dir_out=%0d at=%0d", i,
               vecs[i].tgt, vecs[i].dir, duty_now, dir_out, at_target);
      chk($sformatf("vec%0d_duty", i), int'(duty_now), int'(vecs[i].exp_duty));
      chk($sformatf("vec%0d_dir", i), int'(dir_out), int'(vecs[i].exp_dir));
      chk($sformatf("vec%0d_at", i), int'(at_target), int'(vecs[i].exp_at));
    end

    // Upper clamp: 252 -> 254 with step 4, then full on
    target_duty = 8'd252;
    ramp_to(8'd252, 80);
    target_duty = 8'd254;
    tick(2);
    chk("clamp_254", int'(duty_now), 254);
    target_duty = 8'd255;
    tick(2);
    chk("clamp_255", int'(duty_now), 255);
    pwm_count("pwm_high_255", 255);

    // Lower clamp: reach 3, then target 2 must give 2
    target_duty = 8'd3;
    ramp_to(8'd3, 80);
    target_duty = 8'd2;
    tick(2);
    chk("clamp_2", int'(duty_now), 2);

    target_duty = 8'd64;
    ramp_to(8'd64, 30);
    pwm_count("pwm_high_64", 64);

    target_duty = 8'd0;
    ramp_to(8'd0, 30);
    pwm_count("pwm_high_0", 0);

    // Async reset mid-ramp, asserted between clock edges
    target_duty = 8'd100;
    ramp_to(8'd40, 20);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_duty", int'(duty_now), 0);
    chk("async_rst_dir", int'(dir_out), 0);
    dir_cmd = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    tick(2);
    chk("restart_step", int'(duty_now), 4);

    // A long-held tick is a single step
    tick(1000);
    chk("long_tick", int'(duty_now), 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
